// File: rtl/amm_arb_pkg.sv
// rtl/amm_arb_pkg.sv - shared types and constants for the Avalon-MM round-robin arbiter
package amm_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RDLAT = 2'd2
  } arb_state_e;

  // Read data returned to a master whose read was force-completed by the watchdog
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Width of an index into n requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/amm_rr_picker.sv
// rtl/amm_rr_picker.sv - combinational round-robin picker: first requester at or after rr_ptr
module amm_rr_picker
  import amm_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int PTR_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] pick,
  output logic                   valid
);

  // Walk the requesters starting at rr_ptr, wrapping once, and take the first one set
  always_comb begin
    int idx;
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amm_arbiter.sv
// rtl/amm_arbiter.sv - round-robin Avalon-MM arbiter, one transaction at a time; optional watchdog via AMM_ARB_TIMEOUT_EN
module amm_arbiter
  import amm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*32-1:0]         m_writedata,
  input  logic [NUM_MASTERS-1:0]            m_read,
  output logic [31:0]                       m_readdata,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic                              s_write,
  output logic [31:0]                       s_writedata,
  output logic                              s_read,
  input  logic [31:0]                       s_readdata,
  input  logic                              s_waitrequest,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              timeout_err
);

  localparam int              PTR_W    = idx_width(NUM_MASTERS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       gidx_q, gidx_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   rd_forced_q, rd_forced_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick;
  logic                   pick_valid;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic                   force_done;
  logic                   done;

  assign req = m_write | m_read;

  amm_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .PTR_W      (PTR_W)
  ) u_picker (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Encode the one-hot pick into an index for the command muxes
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  assign next_ptr = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
  assign done     = !s_waitrequest || force_done;

  // Next-state logic: arbitrate in IDLE, wait for acceptance in BUSY, one data cycle in RDLAT
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    rd_forced_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          rr_ptr_d = next_ptr;
          // A master driving both write and read is serviced as a write only
          if (m_write[gidx_q]) begin
            state_d = IDLE;
            grant_d = '0;
          end else begin
            state_d     = RDLAT;
            rd_forced_d = force_done;
          end
        end
      end
      RDLAT: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, ownership and round-robin pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      rd_forced_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_forced_q <= rd_forced_d;
    end
  end

  // Slave command mux and per-master stall; everything idle outside BUSY
  always_comb begin
    s_address     = '0;
    s_write       = 1'b0;
    s_writedata   = '0;
    s_read        = 1'b0;
    m_waitrequest = '1;
    if (state_q == BUSY) begin
      if (!force_done) begin
        s_address   = m_address[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
        s_writedata = m_writedata[int'(gidx_q)*32 +: 32];
        s_write     = m_write[gidx_q];
        s_read      = m_read[gidx_q] & ~m_write[gidx_q];
      end
      m_waitrequest[gidx_q] = s_waitrequest & ~force_done;
    end
  end

  assign m_readdata = rd_forced_q ? TIMEOUT_DATA : s_readdata;
  assign grant      = grant_q;

`ifdef AMM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  assign force_done = (state_q == BUSY) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Count stalled BUSY cycles from zero on each BUSY entry; latch the error on a forced completion
  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q != BUSY) begin
      wd_cnt_d = '0;
    end else if (s_waitrequest && !force_done) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    if (force_done) begin
      timeout_err_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign force_done         = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_amm_arbiter.sv
// tb/tb_amm_arbiter.sv - directed self-checking bench for amm_arbiter (watchdog case under AMM_ARB_TIMEOUT_EN)
module tb_amm_arbiter;

  localparam int AW = 16;
  localparam int NM = 2;

  logic              clk;
  logic              reset_n;
  logic [NM*AW-1:0]  m_address;
  logic [NM-1:0]     m_write;
  logic [NM*32-1:0]  m_writedata;
  logic [NM-1:0]     m_read;
  logic [31:0]       m_readdata;
  logic [NM-1:0]     m_waitrequest;
  logic [AW-1:0]     s_address;
  logic              s_write;
  logic [31:0]       s_writedata;
  logic              s_read;
  logic [31:0]       s_readdata;
  logic              s_waitrequest;
  logic [NM-1:0]     grant;
  logic              timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  amm_arbiter #(
    .ADDR_WIDTH    (AW),
    .NUM_MASTERS   (NM),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m_address    (m_address),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_read       (m_read),
    .m_readdata   (m_readdata),
    .m_waitrequest(m_waitrequest),
    .s_address    (s_address),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_read       (s_read),
    .s_readdata   (s_readdata),
    .s_waitrequest(s_waitrequest),
    .grant        (grant),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    m_address     = '0;
    m_write       = '0;
    m_writedata   = '0;
    m_read        = '0;
    s_readdata    = '0;
    s_waitrequest = 1'b0;
    repeat (3) step();

    check("rst_grant",   grant, 32'h0);
    check("rst_mwait",   m_waitrequest, 32'h3);
    check("rst_swrite",  s_write, 32'h0);
    check("rst_sread",   s_read, 32'h0);
    check("rst_saddr",   s_address, 32'h0);
    check("rst_tmo",     timeout_err, 32'h0);
    reset_n = 1'b1;
    step();

    // single write: master 0, [0x0004] = 0x1234, zero-wait slave
    m_address[0 +: AW]    = 16'h0004;
    m_writedata[0 +: 32]  = 32'h0000_1234;
    m_write[0]            = 1'b1;
    #1;
    check("wr_bubble_swrite", s_write, 32'h0);
    check("wr_bubble_mwait",  m_waitrequest, 32'h3);
    step();
    check("wr_swrite", s_write, 32'h1);
    check("wr_saddr",  s_address, 32'h0004);
    check("wr_sdata",  s_writedata, 32'h0000_1234);
    check("wr_mwait",  m_waitrequest, 32'h2);
    check("wr_grant",  grant, 32'h1);
    step();
    m_write[0] = 1'b0;
    #1;
    check("wr_done_swrite", s_write, 32'h0);
    check("wr_done_grant",  grant, 32'h0);

    // single read: master 1 reads 0x0008, slave returns 0xAA one cycle after acceptance
    m_address[AW +: AW] = 16'h0008;
    m_read[1]           = 1'b1;
    step();
    check("rd_sread", s_read, 32'h1);
    check("rd_saddr", s_address, 32'h0008);
    check("rd_grant", grant, 32'h2);
    check("rd_mwait", m_waitrequest, 32'h1);
    step();
    m_read[1]  = 1'b0;
    s_readdata = 32'h0000_00AA;
    #1;
    check("rd_data",       m_readdata, 32'h0000_00AA);
    check("rd_lat_grant",  grant, 32'h2);
    check("rd_lat_sread",  s_read, 32'h0);
    check("rd_lat_mwait",  m_waitrequest, 32'h3);
    step();
    s_readdata = '0;
    check("rd_idle_grant", grant, 32'h0);

    // contention from reset: both masters write continuously
    reset_n = 1'b0;
    step();
    reset_n     = 1'b1;
    m_address   = {16'h0200, 16'h0100};
    m_writedata = {32'h0000_00B1, 32'h0000_00A0};
    m_write     = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("ct_grant%0d", k), grant, (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("ct_mwait%0d", k), m_waitrequest, (k % 2 == 0) ? 32'h2 : 32'h1);
      check($sformatf("ct_sdata%0d", k), s_writedata, (k % 2 == 0) ? 32'hA0 : 32'hB1);
      step();
      check($sformatf("ct_idle%0d", k), grant, 32'h0);
    end
    m_write = 2'b00;

    // slave stall: master 0 write stalled 5 cycles while master 1 waits
    m_address     = {16'h0020, 16'h0010};
    m_writedata   = {32'h0000_0066, 32'h0000_0055};
    m_write       = 2'b11;
    s_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("st_swrite%0d", i), s_write, 32'h1);
      check($sformatf("st_saddr%0d", i),  s_address, 32'h0010);
      check($sformatf("st_sdata%0d", i),  s_writedata, 32'h55);
      check($sformatf("st_mwait%0d", i),  m_waitrequest, 32'h3);
      check($sformatf("st_grant%0d", i),  grant, 32'h1);
    end
    step();
    s_waitrequest = 1'b0;
    #1;
    check("st_accept_mwait", m_waitrequest, 32'h2);
    check("st_accept_saddr", s_address, 32'h0010);
    step();
    m_write[0] = 1'b0;
    #1;
    check("st_idle_grant", grant, 32'h0);
    step();
    check("st_m1_grant", grant, 32'h2);
    check("st_m1_saddr", s_address, 32'h0020);
    check("st_m1_sdata", s_writedata, 32'h66);
    step();
    m_write = 2'b00;

    // reset asserted during RDLAT of a master 0 read
    m_address[0 +: AW] = 16'h0030;
    m_read[0]          = 1'b1;
    step();
    check("rr_busy_grant", grant, 32'h1);
    check("rr_busy_sread", s_read, 32'h1);
    step();
    m_read[0] = 1'b0;
    #1;
    check("rr_lat_grant", grant, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rr_async_grant", grant, 32'h0);
    check("rr_async_mwait", m_waitrequest, 32'h3);
    check("rr_async_sread", s_read, 32'h0);
    check("rr_async_swrite", s_write, 32'h0);
    step();
    step();
    m_write = 2'b11;
    reset_n = 1'b1;
    step();
    check("rr_after_grant", grant, 32'h1);
    step();
    m_write = 2'b00;
    step();

`ifdef AMM_ARB_TIMEOUT_EN
    // watchdog: master 0 read never accepted by the slave
    m_address[0 +: AW] = 16'h0040;
    m_read[0]          = 1'b1;
    s_waitrequest      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("wd_stall%0d", i), m_waitrequest, 32'h3);
    end
    step();
    check("wd_force_mwait", m_waitrequest, 32'h2);
    check("wd_force_sread", s_read, 32'h0);
    step();
    m_read[0] = 1'b0;
    #1;
    check("wd_data", m_readdata, 32'hDEAD_BEEF);
    check("wd_err",  timeout_err, 32'h1);
    step();
    check("wd_err_sticky", timeout_err, 32'h1);
    s_waitrequest = 1'b0;
    reset_n = 1'b0;
    #1;
    check("wd_err_reset", timeout_err, 32'h0);
    step();
    reset_n = 1'b1;
    step();
`else
    check("no_wd_err", timeout_err, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/amm_arbiter.md
# amm_arbiter

Round-robin Avalon-MM arbiter that shares one waitrequest-based slave (the PID register file) between `NUM_MASTERS` requesters, such as the host bridge and the test-bench AMM master. It carries one transaction at a time. The master-side protocol matches the slave side exactly: commands are held until `waitrequest` is low, and read data arrives one cycle after acceptance. Existing masters therefore connect without any change. The block sits between the master ports and the PID core's register slave.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 16: address width on every port.
- `NUM_MASTERS`, default 2: number of requesters; legal range 2..8.
- `TIMEOUT_CYCLES`, default 256: watchdog limit on stalled slave cycles. Used only when `AMM_ARB_TIMEOUT_EN` is defined.

**Ports**
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m_address`  in  `NUM_MASTERS*ADDR_WIDTH`  per-master address; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `m_write`  in  `NUM_MASTERS`  per-master write request.
- `m_writedata`  in  `NUM_MASTERS*32`  per-master write data, sliced the same way as `m_address`.
- `m_read`  in  `NUM_MASTERS`  per-master read request.
- `m_readdata`  out  32  read data, broadcast to all masters.
- `m_waitrequest`  out  `NUM_MASTERS`  per-master stall.
- `s_address`, `s_write`, `s_writedata`, `s_read`  out  `ADDR_WIDTH`/1/32/1  slave command.
- `s_readdata`  in  32  slave read data.
- `s_waitrequest`  in  1  slave stall.
- `grant`  out  `NUM_MASTERS`  one-hot current owner; all zeros when idle.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation

**State machine:** IDLE, BUSY, RDLAT.

**IDLE**
- Build the request vector: `req[i] = m_write[i] | m_read[i]`.
- If any request is set, pick the first requester at or after `rr_ptr` (wrapping modulo `NUM_MASTERS`).
- Register the winner into `grant` and go to BUSY.
- All `m_waitrequest` bits are 1.
- All `s_*` command outputs are 0.

**BUSY**
- The `s_*` command outputs are a combinational mux of the granted master's signals.
- `m_waitrequest[g] = s_waitrequest`; every other bit is 1.
- Acceptance is the cycle in which `s_waitrequest` is 0.
- On acceptance, set `rr_ptr = (g+1) mod NUM_MASTERS`.
- After acceptance, a write goes to IDLE and a read goes to RDLAT.
- If a master asserts both `m_write` and `m_read`, it is treated as a write; the read is not serviced.

**RDLAT**
- `m_readdata` passes `s_readdata` through for one cycle.
- Then go to IDLE and clear `grant`.

**Other rules**
- `m_readdata` equals `s_readdata` in every state. It is meaningful only in RDLAT, and only to the granted master.
- Masters must hold their command until they see `m_waitrequest` low. Withdrawing a request while in BUSY is a protocol violation and is not handled.
- Reset (asynchronous, any state): state returns to IDLE, `rr_ptr` to 0, `grant` to 0, and `timeout_err` to 0. All `m_waitrequest` bits go to 1 and all `s_*` outputs go to 0. A slave transaction in flight is abandoned.

## Timing

- Arbitration costs one bubble cycle: a request seen in IDLE at cycle t appears on `s_*` at t+1.
- Write with zero-wait slave: accepted at t+1, IDLE at t+2. A new grant can be issued from t+2, so the best case is one transaction every 2 cycles.
- Read with zero-wait slave: accepted at t+1, data at t+2 (RDLAT), IDLE at t+3.
- Each cycle of `s_waitrequest` held high adds one cycle to BUSY.
- Round-robin fairness: with all masters requesting continuously, each master is served at least once every `NUM_MASTERS` transactions.

## Configuration

**`AMM_ARB_TIMEOUT_EN` defined**
- A counter clears on entry to BUSY and increments on each BUSY cycle with `s_waitrequest` high.
- When the counter reaches `TIMEOUT_CYCLES`, force completion in that cycle:
  - drive `m_waitrequest[g]` to 0;
  - drive the `s_*` command outputs to 0;
  - set `timeout_err` (sticky until reset).
- A forced read then goes to RDLAT with `m_readdata = TIMEOUT_DATA` (32'hDEAD_BEEF) in place of `s_readdata`.
- A forced write goes to IDLE.
- `rr_ptr` advances as it would on normal acceptance.

**`AMM_ARB_TIMEOUT_EN` undefined**
- No counter is built.
- `timeout_err` is tied to 0.
- BUSY waits on `s_waitrequest` indefinitely.

## Structure

- Package `amm_arb_pkg` holds:
  - the `arb_state_e` enum (IDLE, BUSY, RDLAT);
  - the `TIMEOUT_DATA` constant.
- Sub-module `amm_rr_picker` is purely combinational:
  - inputs: `req[NUM_MASTERS]`, `rr_ptr`;
  - outputs: one-hot `pick` and a `valid` flag.
- The parent owns the FSM, `rr_ptr`, `grant`, the muxes and the watchdog.

## Test plan

- **Single write.** Master 0 writes [0x0004]=0x0000_1234 to a zero-wait slave.
  - `s_write` high exactly one cycle with the same address and data.
  - `m_waitrequest[0]` low on that cycle.
  - `grant` = 01 during BUSY.
- **Single read.** Master 1 reads 0x0008; the slave returns 0x0000_00AA with latency 1.
  - `m_readdata` = 0xAA in the RDLAT cycle.
  - The transaction takes 3 cycles in total.
- **Contention.** Both masters request continuously from reset, for 4 transactions each.
  - Grant order is 0,1,0,1,...
  - Neither master is ever served twice in a row while the other is waiting.
- **Slave stall.** `s_waitrequest` held high for 5 cycles on a granted write.
  - `s_*` stays stable, `m_waitrequest[g]` stays high, and the other master stays blocked.
  - Completion follows on the 6th cycle.
- **Reset mid-read.** `reset_n` pulses low while in RDLAT.
  - All outputs return to their reset values asynchronously.
  - After release, the next request is served starting from master 0.
- **Watchdog** (`AMM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16). A read where `s_waitrequest` never drops.
  - Forced completion after 16 stalled cycles.
  - `m_readdata` = 0xDEAD_BEEF and `timeout_err` = 1, remaining 1 until reset.
